// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// Conflicts alternate between the two, and each transaction aborts after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_ack,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic                      d_ack,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                 state;
  logic                   owner_d;       // 1 = data port owns the transaction
  logic                   last_owner_d;  // 1 = data port was granted last
  logic [CNT_WIDTH-1:0]   wait_cnt;
  logic                   grant_d_c;
  logic                   timeout_c;
  logic [DATA_WIDTH-1:0]  load_word_c;

  // On conflict the port that was not served last wins.
  assign grant_d_c   = d_req && (!if_req || !last_owner_d);
  assign timeout_c   = (wait_cnt == WAIT_LAST);
  assign load_word_c = (mem_ready && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_owner_d <= 1'b1;
      wait_cnt     <= '0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_d      <= grant_d_c;
            last_owner_d <= grant_d_c;
            mem_req      <= 1'b1;
            mem_we       <= grant_d_c ? d_we : 1'b0;
            mem_addr     <= grant_d_c ? d_addr : if_addr;
            mem_wdata    <= grant_d_c ? d_wdata : '0;
            mem_be       <= grant_d_c ? d_be : '1;
            wait_cnt     <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Completion or abort; a timed-out transaction returns zero data.
          if (mem_ready || timeout_c) begin
            mem_req <= 1'b0;
            err     <= !mem_ready;
            state   <= ACK;
            if (owner_d) begin
              d_ack   <= 1'b1;
              d_rdata <= load_word_c;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= load_word_c;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction-level model: phase 0 = no transaction, 1 = at memory, 2 = acknowledging.
  int            phase;
  int            waited;
  bit            m_own_d;
  bit            m_last_d;
  bit            fin;
  bit            fin_err;
  logic [DW-1:0] fin_data;
  logic          exp_if_ack, exp_d_ack, exp_err, exp_mem_req, exp_mem_we;
  logic [DW-1:0] exp_if_rdata, exp_d_rdata, exp_mem_wdata;
  logic [AW-1:0] exp_mem_addr;
  logic [3:0]    exp_mem_be;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0; waited = 0; m_own_d = 1'b0; m_last_d = 1'b1;
      exp_if_ack = 0; exp_d_ack = 0; exp_err = 0; exp_mem_req = 0; exp_mem_we = 0;
      exp_if_rdata = 0; exp_d_rdata = 0; exp_mem_wdata = 0; exp_mem_addr = 0; exp_mem_be = 0;
    end else begin
      exp_if_ack = 0; exp_d_ack = 0; exp_err = 0;
      fin = 0; fin_err = 0; fin_data = 0;
      if (phase == 2) begin
        phase = 0;
      end else if (phase == 1) begin
        if (mem_ready) begin
          fin = 1; fin_data = exp_mem_we ? 32'h0 : mem_rdata;
        end else begin
          waited++;
          if (waited == int'(TO)) begin fin = 1; fin_err = 1; end
        end
        if (fin) begin
          phase = 2; exp_mem_req = 0; exp_err = fin_err;
          if (m_own_d) begin exp_d_ack = 1; exp_d_rdata = fin_data; end
          else begin exp_if_ack = 1; exp_if_rdata = fin_data; end
        end
      end else if (if_req || d_req) begin
        m_own_d       = (if_req && d_req) ? !m_last_d : d_req;
        m_last_d      = m_own_d;
        exp_mem_req   = 1;
        exp_mem_we    = m_own_d ? d_we : 1'b0;
        exp_mem_addr  = m_own_d ? d_addr : if_addr;
        exp_mem_wdata = m_own_d ? d_wdata : 32'h0;
        exp_mem_be    = m_own_d ? d_be : 4'hF;
        waited = 0; phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("if_ack",    64'(if_ack),    64'(exp_if_ack));
      check("if_rdata",  64'(if_rdata),  64'(exp_if_rdata));
      check("d_ack",     64'(d_ack),     64'(exp_d_ack));
      check("d_rdata",   64'(d_rdata),   64'(exp_d_rdata));
      check("err",       64'(err),       64'(exp_err));
      check("mem_req",   64'(mem_req),   64'(exp_mem_req));
      check("mem_we",    64'(mem_we),    64'(exp_mem_we));
      check("mem_addr",  64'(mem_addr),  64'(exp_mem_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(exp_mem_wdata));
      check("mem_be",    64'(mem_be),    64'(exp_mem_be));
    end
  end

  int order[$];

  initial begin
    rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_ready = 0; mem_rdata = 0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_be", 64'(mem_be), 64'h0);
    check("rst_if_ack", 64'(if_ack), 64'h0);
    check("rst_d_rdata", 64'(d_rdata), 64'h0);
    check("rst_err", 64'(err), 64'h0);

    // Single fetch, memory always ready
    tick();
    rst = 1'b0; if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h13;
    @(posedge clk);
    @(negedge clk);
    check("f_mem_req_c1", 64'(mem_req), 64'h1);
    check("f_mem_addr_c1", 64'(mem_addr), 64'h10);
    check("f_mem_be_c1", 64'(mem_be), 64'hF);
    check("f_mem_we_c1", 64'(mem_we), 64'h0);
    @(negedge clk);
    check("f_if_ack_c2", 64'(if_ack), 64'h1);
    check("f_if_rdata_c2", 64'(if_rdata), 64'h13);
    check("f_err_c2", 64'(err), 64'h0);
    check("f_mem_req_c2", 64'(mem_req), 64'h0);
    tick();
    if_req = 0;
    tick();

    // Both requesters from reset: fetch first, then alternate
    rst = 1'b1;
    tick();
    rst = 1'b0; if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h300;
    d_be = 4'h5; mem_ready = 1; mem_rdata = 32'h55;
    @(posedge clk);
    repeat (12) begin
      @(negedge clk);
      if (if_ack) order.push_back(0);
      if (d_ack)  order.push_back(1);
    end
    check("alt_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check("alt_owner", 64'(order[i]), 64'(i % 2));
    check("alt_d_rdata", 64'(d_rdata), 64'h55);
    tick();
    if_req = 0; d_req = 0;
    repeat (3) tick();

    // Data load that never completes: timeout after TO waiting cycles
    d_req = 1; d_we = 0; d_addr = 32'h40; mem_ready = 0; mem_rdata = 32'hAAAA;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_mem_req_busy", 64'(mem_req), 64'h1);
      check("to_no_ack_busy", 64'(d_ack), 64'h0);
    end
    @(negedge clk);
    check("to_d_ack", 64'(d_ack), 64'h1);
    check("to_err", 64'(err), 64'h1);
    check("to_d_rdata", 64'(d_rdata), 64'h0);
    check("to_mem_req_ack", 64'(mem_req), 64'h0);
    tick();
    d_req = 0;
    repeat (2) tick();

    // Store with three wait cycles; fields held while waiting
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    mem_ready = 0; mem_rdata = 32'h1234;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("st_mem_req", 64'(mem_req), 64'h1);
      check("st_mem_we", 64'(mem_we), 64'h1);
      check("st_mem_addr", 64'(mem_addr), 64'h200);
      check("st_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      check("st_mem_be", 64'(mem_be), 64'h3);
      check("st_no_ack", 64'(d_ack), 64'h0);
      if (k == 3) begin
        @(posedge clk);
        #2 mem_ready = 1;
      end
    end
    @(negedge clk);
    check("st_d_ack", 64'(d_ack), 64'h1);
    check("st_d_rdata", 64'(d_rdata), 64'h0);
    check("st_err", 64'(err), 64'h0);
    tick();
    d_req = 0; mem_ready = 0;
    repeat (2) tick();

    // Reset during BUSY abandons the fetch
    if_req = 1; if_addr = 32'h80; mem_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mr_mem_req", 64'(mem_req), 64'h0);
    check("mr_mem_addr", 64'(mem_addr), 64'h0);
    check("mr_mem_be", 64'(mem_be), 64'h0);
    check("mr_if_ack", 64'(if_ack), 64'h0);
    if_req = 0;
    tick();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("mr_no_ack", 64'(if_ack), 64'h0);
      check("mr_no_err", 64'(err), 64'h0);
    end
    // Re-issued fetch, then held through ACK: no regrant until after ACK
    tick();
    if_req = 1; mem_ready = 1; mem_rdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    check("ri_mem_req_c1", 64'(mem_req), 64'h1);
    check("ri_mem_addr_c1", 64'(mem_addr), 64'h80);
    @(negedge clk);
    check("ri_if_ack_c2", 64'(if_ack), 64'h1);
    check("ri_if_rdata_c2", 64'(if_rdata), 64'h77);
    @(negedge clk);
    check("hold_mem_req_c3", 64'(mem_req), 64'h0);
    check("hold_if_ack_c3", 64'(if_ack), 64'h0);
    @(negedge clk);
    check("hold_mem_req_c4", 64'(mem_req), 64'h1);
    tick();
    if_req = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
